id_stage_hz: RTL and testbench

Parametrised RV32 instruction-decode stage for the 5-stage pipeline, sitting between the IF/ID and ID/EX boundaries. Contains the register file and a valid/ready ID/EX pipeline register. Adds load-use and branch-operand hazard interlock with bubble insertion, plus flush support. Resolves JAL, JALR and the BEQ/BNE/BLT/BGE branches in ID.

---
 rtl/id_stage_hz.sv | 208 ++++++++++++++++++++
 tb/tb_id_stage_hz.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_hz.sv
// RV32 decode stage: register file, decode, ID-resolved jumps/branches, hazard interlock
// and a valid/ready ID/EX register. Define ID_BYPASS_EN for write-first register reads.
module id_stage_hz #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [XLEN-1:0]             in_pc,
  input  logic [XLEN-1:0]             in_pc4,
  input  logic [31:0]                 in_instr,
  input  logic                        flush,
  input  logic                        wb_en,
  input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
  input  logic [XLEN-1:0]             wb_data,
  input  logic                        ex_ready,
  output logic                        out_valid,
  output logic [8:0]                  ctrl_ex,
  output logic [XLEN-1:0]             pc4_ex,
  output logic [XLEN-1:0]             r_data1,
  output logic [XLEN-1:0]             r_data2,
  output logic [XLEN-1:0]             extended,
  output logic [$clog2(NUM_REGS)-1:0] rd_ex,
  output logic                        illegal_ex,
  output logic                        control_j,
  output logic [XLEN-1:0]             pc_j
);
  localparam int AW = $clog2(NUM_REGS);

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  // {reg_write, mem_to_reg, mem_read, mem_write, alu_src, alu_op[3:0]}
  localparam logic [8:0] C_ADDI  = 9'b1_0_0_0_1_0000;
  localparam logic [8:0] C_LOAD  = 9'b1_1_1_0_1_0000;
  localparam logic [8:0] C_STORE = 9'b0_0_0_1_1_0000;
  localparam logic [8:0] C_ADD   = 9'b1_0_0_0_0_0000;
  localparam logic [8:0] C_SUB   = 9'b1_0_0_0_0_0001;
  localparam logic [8:0] C_SLL   = 9'b1_0_0_0_0_0010;
  localparam logic [8:0] C_SLT   = 9'b1_0_0_0_0_0011;
  localparam logic [8:0] C_AND   = 9'b1_0_0_0_0_0100;
  localparam logic [8:0] C_OR    = 9'b1_0_0_0_0_0101;
  localparam logic [8:0] C_JMP   = 9'b1_0_0_0_0_1111;

  logic [6:0]    opc, f7;
  logic [2:0]    f3;
  logic [AW-1:0] rs1_a, rs2_a, rd_a;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign rd_a  = in_instr[7 +: AW];
  assign rs1_a = in_instr[15 +: AW];
  assign rs2_a = in_instr[20 +: AW];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
  assign imm_i = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
  assign imm_s = {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
  assign imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  // Register file; entry 0 is never written and is masked on read
  logic [XLEN-1:0] rf_q [NUM_REGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  logic [XLEN-1:0] rs1_v, rs2_v;

  always_comb begin
    rs1_v = (rs1_a == '0) ? '0 : rf_q[rs1_a];
    rs2_v = (rs2_a == '0) ? '0 : rf_q[rs2_a];
`ifdef ID_BYPASS_EN
    if (wb_en && wb_addr != '0 && wb_addr == rs1_a) rs1_v = wb_data;
    if (wb_en && wb_addr != '0 && wb_addr == rs2_a) rs2_v = wb_data;
`endif
  end

  logic [8:0]      ctrl_d;
  logic            ill_d, use1, use2, is_br, is_jal, is_jalr, br_take;
  logic [XLEN-1:0] imm_d;
  logic            eq, lt;

  assign eq = (rs1_v == rs2_v);
  assign lt = ($signed(rs1_v) < $signed(rs2_v));

  always_comb begin
    ctrl_d  = '0;
    ill_d   = 1'b0;
    imm_d   = '0;
    use1    = 1'b0;
    use2    = 1'b0;
    is_br   = 1'b0;
    is_jal  = 1'b0;
    is_jalr = 1'b0;
    br_take = 1'b0;
    case (opc)
      OP_IMM: begin
        if (f3 == 3'b000) begin ctrl_d = C_ADDI; imm_d = imm_i; use1 = 1'b1; end
        else ill_d = 1'b1;
      end
      OP_LOAD:  begin ctrl_d = C_LOAD;  imm_d = imm_i; use1 = 1'b1; end
      OP_STORE: begin ctrl_d = C_STORE; imm_d = imm_s; use1 = 1'b1; use2 = 1'b1; end
      OP_R: begin
        use1 = 1'b1;
        use2 = 1'b1;
        case (f3)
          3'b000: begin
            if (f7 == 7'b0000000)      ctrl_d = C_ADD;
            else if (f7 == 7'b0100000) ctrl_d = C_SUB;
            else                       ill_d  = 1'b1;
          end
          3'b001:  ctrl_d = C_SLL;
          3'b010:  ctrl_d = C_SLT;
          3'b111:  ctrl_d = C_AND;
          3'b110:  ctrl_d = C_OR;
          default: ill_d  = 1'b1;
        endcase
      end
      OP_JAL: begin ctrl_d = C_JMP; imm_d = imm_j; is_jal = 1'b1; end
      OP_JALR: begin
        if (f3 == 3'b000) begin ctrl_d = C_JMP; imm_d = imm_i; use1 = 1'b1; is_jalr = 1'b1; end
        else ill_d = 1'b1;
      end
      OP_BR: begin
        imm_d = imm_b;
        case (f3)
          3'b000:  begin is_br = 1'b1; br_take = eq;  end
          3'b001:  begin is_br = 1'b1; br_take = !eq; end
          3'b100:  begin is_br = 1'b1; br_take = lt;  end
          3'b101:  begin is_br = 1'b1; br_take = !lt; end
          default: ill_d = 1'b1;
        endcase
        use1 = is_br;
        use2 = is_br;
      end
      default: ill_d = 1'b1;
    endcase
  end

  logic            out_valid_q, ill_q;
  logic [8:0]      ctrl_q;
  logic [XLEN-1:0] pc4_q, r1_q, r2_q, ext_q;
  logic [AW-1:0]   rd_q;

  logic [XLEN-1:0] jalr_sum;
  logic            src_hit, hz, adv;

  assign jalr_sum = rs1_v + imm_i;
  assign pc_j     = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : in_pc + imm_d;

  // Load-use always interlocks; ALU results interlock only for operands consumed in ID
  assign src_hit  = (use1 && rs1_a == rd_q) || (use2 && rs2_a == rd_q);
  assign hz       = in_valid && out_valid_q && rd_q != '0 && src_hit &&
                    (ctrl_q[6] || (ctrl_q[8] && (is_br || is_jalr)));
  assign adv      = ex_ready || !out_valid_q;
  assign in_ready = flush || (adv && !hz);
  assign control_j = in_valid && in_ready && !flush && (is_jal || is_jalr || br_take);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      ill_q       <= 1'b0;
      pc4_q       <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      ext_q       <= '0;
      rd_q        <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (adv) begin
      if (in_valid && !hz) begin
        out_valid_q <= 1'b1;
        ctrl_q      <= ctrl_d;
        ill_q       <= ill_d;
        pc4_q       <= in_pc4;
        r1_q        <= rs1_v;
        r2_q        <= rs2_v;
        ext_q       <= imm_d;
        rd_q        <= ctrl_d[8] ? rd_a : '0;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign ctrl_ex    = ctrl_q;
  assign illegal_ex = ill_q;
  assign pc4_ex     = pc4_q;
  assign r_data1    = r1_q;
  assign r_data2    = r2_q;
  assign extended   = ext_q;
  assign rd_ex      = rd_q;
endmodule

// File: tb/tb_id_stage_hz.sv
// Scoreboard bench for id_stage_hz: directed instructions, monitor checks each ID/EX handshake.
module tb_id_stage_hz;
  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, flush, wb_en, ex_ready, out_valid;
  logic        illegal_ex, control_j;
  logic [31:0] in_pc, in_pc4, in_instr, wb_data, pc4_ex, r_data1, r_data2, extended, pc_j;
  logic [4:0]  wb_addr, rd_ex;
  logic [8:0]  ctrl_ex;

  id_stage_hz #(.XLEN(32), .NUM_REGS(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc4(in_pc4), .in_instr(in_instr), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .ex_ready(ex_ready),
    .out_valid(out_valid), .ctrl_ex(ctrl_ex), .pc4_ex(pc4_ex), .r_data1(r_data1),
    .r_data2(r_data2), .extended(extended), .rd_ex(rd_ex), .illegal_ex(illegal_ex),
    .control_j(control_j), .pc_j(pc_j)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [3:0] ALL = 4'b1111;
  localparam logic [3:0] NO_R2 = 4'b1101;  // mask bits: {rd, ext, r2, r1}
  localparam logic [3:0] NO_EXT = 4'b1011;

  typedef struct {
    logic [8:0]  ctrl;
    logic [31:0] r1, r2, ext, pc4;
    logic [4:0]  rd;
    logic        ill;
    logic [3:0]  m;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_rf [32];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [8:0] c, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] ext, input logic [4:0] rd, input logic [31:0] pc4,
                      input logic ill, input logic [3:0] m);
    exp_t e;
    e.ctrl = c; e.r1 = r1; e.r2 = r2; e.ext = ext; e.rd = rd; e.pc4 = pc4; e.ill = ill; e.m = m;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && ex_ready && (ctrl_ex != 9'd0 || illegal_ex)) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: got ctrl %0h with nothing expected", ctrl_ex);
      end else begin
        me = sb.pop_front();
        chk("mon_ctrl", {55'd0, ctrl_ex}, {55'd0, me.ctrl});
        chk("mon_ill", {63'd0, illegal_ex}, {63'd0, me.ill});
        chk("mon_pc4", {32'd0, pc4_ex}, {32'd0, me.pc4});
        if (me.m[0]) chk("mon_r1", {32'd0, r_data1}, {32'd0, me.r1});
        if (me.m[1]) chk("mon_r2", {32'd0, r_data2}, {32'd0, me.r2});
        if (me.m[2]) chk("mon_ext", {32'd0, extended}, {32'd0, me.ext});
        if (me.m[3]) chk("mon_rd", {59'd0, rd_ex}, {59'd0, me.rd});
      end
    end
  end

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                        input logic [31:0] f3, input logic [31:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3, input logic [31:0] rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    cyc();
    wb_en = 1'b0;
    if (a != 5'd0) m_rf[a] = d;
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc; in_pc4 = pc + 32'd4;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic jexp,
                      input logic [31:0] pcj, input string nm);
    present(ins, pc);
    @(negedge clk);
    chk({nm, "_rdy"}, {63'd0, in_ready}, 64'd1);
    chk({nm, "_cj"}, {63'd0, control_j}, {63'd0, jexp});
    if (jexp) chk({nm, "_pcj"}, {32'd0, pc_j}, {32'd0, pcj});
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; ex_ready = 1'b1;
    in_pc = 0; in_pc4 = 0; in_instr = 0; wb_addr = 0; wb_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ov", {63'd0, out_valid}, 64'd0);
    chk("rst_ctrl", {55'd0, ctrl_ex}, 64'd0);
    chk("rst_ill", {63'd0, illegal_ex}, 64'd0);
    chk("rst_rdy", {63'd0, in_ready}, 64'd1);
    #2 reset_n = 1'b1;
    cyc();

    // ADDI x12,x20,7
    wb(5'd20, 32'd8);
    push(9'b100010000, 32'd8, 32'd0, 32'd7, 5'd12, 32'd404, 1'b0, NO_R2);
    send(enc_i(7, 20, 0, 12, OP_IMM), 32'd400, 1'b0, 32'd0, "t1");
    @(negedge clk);
    chk("t1_ov", {63'd0, out_valid}, 64'd1);
    cyc();

    // load-use: LW x5,0(x1) then ADD x6,x5,x2
    wb(5'd1, 32'h40);
    wb(5'd2, 32'h7);
    push(9'b111010000, 32'h40, 32'd0, 32'd0, 5'd5, 32'h14, 1'b0, NO_R2);
    send(enc_i(0, 1, 2, 5, OP_LOAD), 32'h10, 1'b0, 32'd0, "t2_lw");
    present(enc_r(0, 2, 5, 0, 6), 32'h14);
    @(negedge clk);
    chk("t2_stall", {63'd0, in_ready}, 64'd0);
    cyc();
    @(negedge clk);
    chk("t2_bubble", {63'd0, out_valid}, 64'd0);
    chk("t2_release", {63'd0, in_ready}, 64'd1);
    push(9'b100000000, 32'd0, 32'h7, 32'd0, 5'd6, 32'h18, 1'b0, NO_EXT);
    cyc();
    in_valid = 1'b0;

    // branches
    wb(5'd1, 32'd3);
    wb(5'd2, 32'd3);
    send(enc_b(16, 2, 1, 0), 32'd100, 1'b1, 32'd116, "t3_beq_t");
    @(negedge clk);
    chk("t3_br_ctrl", {55'd0, ctrl_ex}, 64'd0);
    chk("t3_br_ill", {63'd0, illegal_ex}, 64'd0);
    wb(5'd2, 32'd4);
    send(enc_b(16, 2, 1, 0), 32'd100, 1'b0, 32'd0, "t3_beq_nt");
    send(enc_b(16, 2, 1, 1), 32'd100, 1'b1, 32'd116, "t3_bne_t");
    wb(5'd2, 32'hFFFF_FFFF);
    send(enc_b(32'hFFFF_FFF8, 2, 1, 4), 32'd200, 1'b0, 32'd0, "t3_blt_nt");
    send(enc_b(32'hFFFF_FFF8, 2, 1, 5), 32'd200, 1'b1, 32'd192, "t3_bge_t");

    // JALR x1,x3,5 and JAL x1,+0x40
    wb(5'd3, 32'h200);
    push(9'b100001111, 32'h200, 32'd0, 32'd5, 5'd1, 32'h304, 1'b0, NO_R2);
    send(enc_i(5, 3, 0, 1, OP_JALR), 32'h300, 1'b1, 32'h204, "t4_jalr");
    push(9'b100001111, 32'd0, 32'd0, 32'h40, 5'd1, 32'h504, 1'b0, 4'b1100);
    send(enc_j(32'h40, 1), 32'h500, 1'b1, 32'h540, "t4_jal");
    cyc();

    // EX back-pressure then flush
    ex_ready = 1'b0;
    send(enc_i(5, 0, 0, 8, OP_IMM), 32'h600, 1'b0, 32'd0, "t5_acc");
    present(enc_j(32'h40, 0), 32'h604);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_ov", {63'd0, out_valid}, 64'd1);
      chk("t5_ctrl", {55'd0, ctrl_ex}, 64'h110);
      chk("t5_rd", {59'd0, rd_ex}, 64'd8);
      chk("t5_ext", {32'd0, extended}, 64'd5);
      chk("t5_pc4", {32'd0, pc4_ex}, 64'h604);
      chk("t5_rdy", {63'd0, in_ready}, 64'd0);
      chk("t5_cj", {63'd0, control_j}, 64'd0);
      cyc();
    end
    flush = 1'b1;
    @(negedge clk);
    chk("t5_fl_rdy", {63'd0, in_ready}, 64'd1);
    chk("t5_fl_cj", {63'd0, control_j}, 64'd0);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t5_fl_ov", {63'd0, out_valid}, 64'd0);
    cyc();
    ex_ready = 1'b1;

    // branch-operand interlock: ADDI x7 then BEQ x7,x0
    push(9'b100010000, 32'd0, 32'd0, 32'd1, 5'd7, 32'h704, 1'b0, NO_R2);
    send(enc_i(1, 0, 0, 7, OP_IMM), 32'h700, 1'b0, 32'd0, "t7_addi");
    present(enc_b(8, 0, 7, 0), 32'h704);
    @(negedge clk);
    chk("t7_stall", {63'd0, in_ready}, 64'd0);
    chk("t7_stall_cj", {63'd0, control_j}, 64'd0);
    cyc();
    @(negedge clk);
    chk("t7_rel", {63'd0, in_ready}, 64'd1);
    chk("t7_cj", {63'd0, control_j}, 64'd1);
    chk("t7_pcj", {32'd0, pc_j}, 64'h70C);
    cyc();
    in_valid = 1'b0;

    // same-cycle write-back to x9 while ADD x10,x9,x0 is decoded
    wb(5'd9, 32'h11);
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hAB;
`ifdef ID_BYPASS_EN
    push(9'b100000000, 32'hAB, 32'd0, 32'd0, 5'd10, 32'h804, 1'b0, NO_EXT);
`else
    push(9'b100000000, 32'h11, 32'd0, 32'd0, 5'd10, 32'h804, 1'b0, NO_EXT);
`endif
    present(enc_r(0, 0, 9, 0, 10), 32'h800);
    @(negedge clk);
    chk("t6_rdy", {63'd0, in_ready}, 64'd1);
    cyc();
    wb_en = 1'b0; in_valid = 1'b0;
    m_rf[9] = 32'hAB;
    wb(5'd0, 32'h55);
    push(9'b100000000, 32'd0, 32'hAB, 32'd0, 5'd11, 32'h80C, 1'b0, NO_EXT);
    send(enc_r(0, 9, 0, 0, 11), 32'h808, 1'b0, 32'd0, "t6_x0");

    // illegal, SUB, OR, SW
    push(9'd0, 32'd0, 32'd0, 32'd0, 5'd0, 32'h904, 1'b1, ALL);
    send(32'h0000_007F, 32'h900, 1'b0, 32'd0, "t8_ill");
    push(9'b100000001, 32'd3, 32'hFFFF_FFFF, 32'd0, 5'd13, 32'hA04, 1'b0, NO_EXT);
    send(enc_r(7'b0100000, 2, 1, 0, 13), 32'hA00, 1'b0, 32'd0, "t8_sub");
    push(9'b100000101, 32'd3, 32'hFFFF_FFFF, 32'd0, 5'd14, 32'hA08, 1'b0, NO_EXT);
    send(enc_r(0, 2, 1, 6, 14), 32'hA04, 1'b0, 32'd0, "t8_or");
    push(9'b000110000, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 5'd0, 32'hA0C, 1'b0, 4'b0111);
    send(enc_s(32'hFFFF_FFFC, 2, 1, 2), 32'hA08, 1'b0, 32'd0, "t8_sw");

    // reset while a load-use stall is pending
    push(9'b111010000, 32'd3, 32'd0, 32'd0, 5'd5, 32'hB04, 1'b0, NO_R2);
    send(enc_i(0, 1, 2, 5, OP_LOAD), 32'hB00, 1'b0, 32'd0, "t9_lw");
    present(enc_r(0, 2, 5, 0, 6), 32'hB04);
    @(negedge clk);
    chk("t9_stall", {63'd0, in_ready}, 64'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("t9_rst_ov", {63'd0, out_valid}, 64'd0);
    chk("t9_rst_rdy", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    cyc();
    reset_n = 1'b1;
    cyc();
    push(9'b100000000, 32'd0, 32'd0, 32'd0, 5'd12, 32'hC04, 1'b0, NO_EXT);
    send(enc_r(0, 2, 1, 0, 12), 32'hC00, 1'b0, 32'd0, "t9_rf_clr");

    repeat (3) cyc();
    chk("sb_drain", sb.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
